// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one single-port synchronous
// memory. Read data is returned to the requester that issued the read.
module shared_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [CNT_W-1:0]          grant_total,
  output logic [CNT_W-1:0]          conflict_cycles
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic               accept;
  logic               conflict;
  logic [ID_W-1:0]    mem_id;

  logic [MEM_LAT-1:0]           tag_rd;
  logic [MEM_LAT-1:0][ID_W-1:0] tag_id;

  // Handshake: request i transfers in a cycle where req_valid[i] && req_ready[i];
  // the requester holds its fields stable until then, and may drop valid early.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_any && rst_n) grant_oh[grant_id] = 1'b1;
  end

  assign req_ready = grant_oh;
  assign accept    = |grant_oh;
  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign conflict  = |(req_valid & (req_valid - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_id    <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & req_we[grant_id];
      if (accept) begin
        rr_ptr    <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        mem_id    <= grant_id;
        mem_addr  <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[int'(grant_id)*DATA_W +: DATA_W];
      end
    end
  end

  // Tag stage MEM_LAT-1 lines up with the cycle in which mem_rdata is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_rd    <= '0;
      tag_id    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      tag_rd[0] <= mem_en & ~mem_we;
      tag_id[0] <= mem_id;
      for (int s = 1; s < MEM_LAT; s++) begin
        tag_rd[s] <= tag_rd[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      rsp_valid <= '0;
      if (tag_rd[MEM_LAT-1]) begin
        rsp_valid[tag_id[MEM_LAT-1]] <= 1'b1;
        rsp_rdata                    <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_total     <= '0;
      conflict_cycles <= '0;
    end else begin
      if (accept && (grant_total != '1))
        grant_total <= grant_total + 1'b1;
      if (conflict && (conflict_cycles != '1))
        conflict_cycles <= conflict_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: instance a (MEM_LAT=1, CNT_W=4) and
// instance b (MEM_LAT=3, CNT_W=16) share one stimulus; each has its own memory model.
module tb_shared_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [AW-1:0]   addr_v [N];
  logic [DW-1:0]   wdata_v [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_v[i];
      req_wdata[i*DW +: DW] = wdata_v[i];
    end
  end

  logic [N-1:0]  a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic          a_mem_en, a_mem_we, b_mem_en, b_mem_we;
  logic [AW-1:0] a_mem_addr, b_mem_addr;
  logic [DW-1:0] a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;
  logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
  logic [3:0]    a_grant_total, a_conflict;
  logic [15:0]   b_grant_total, b_conflict;

  shared_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .grant_total(a_grant_total), .conflict_cycles(a_conflict)
  );

  shared_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .grant_total(b_grant_total), .conflict_cycles(b_conflict)
  );

  // memory models: 1-cycle and 3-cycle read latency
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] a_rd_q, b_p0, b_p1, b_p2;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    a_rd_q = '0; b_p0 = '0; b_p1 = '0; b_p2 = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    if (a_mem_en && !a_mem_we) a_rd_q <= mem_a[a_mem_addr];
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    if (b_mem_en && !b_mem_we) b_p0 <= mem_b[b_mem_addr];
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign a_mem_rdata = a_rd_q;
  assign b_mem_rdata = b_p2;

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive just after the rising edge, sample on the falling edge
  task automatic tick(input logic [N-1:0] v, input logic [N-1:0] we);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_rdy, exp_a, exp_b, v;

    // reset state: ready stays low even with every requester valid
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_ready_a", a_ready, 4'b0000);
    chk("rst_ready_b", b_ready, 4'b0000);
    chk("rst_mem_en", a_mem_en, 1'b0);
    chk("rst_mem_addr", a_mem_addr, 8'h00);
    chk("rst_rsp_valid", a_rsp_valid, 4'b0000);
    chk("rst_grant_total", b_grant_total, 16'd0);
    chk("rst_conflict", b_conflict, 16'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;

    // single requester: write then read of the same address
    addr_v[2]  = 8'h10;
    wdata_v[2] = 32'hDEADBEEF;
    tick(4'b0100, 4'b0100);
    chk("t1_ready_wr", a_ready, 4'b0100);
    tick(4'b0100, 4'b0000);
    chk("t1_ready_rd", a_ready, 4'b0100);
    chk("t1_mem_en_wr", a_mem_en, 1'b1);
    chk("t1_mem_we_wr", a_mem_we, 1'b1);
    chk("t1_mem_addr", a_mem_addr, 8'h10);
    chk("t1_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    tick(4'b0000, 4'b0000);
    chk("t1_ready_idle", a_ready, 4'b0000);
    chk("t1_mem_en_rd", a_mem_en, 1'b1);
    chk("t1_mem_we_rd", a_mem_we, 1'b0);
    chk("t1_grant_total", a_grant_total, 4'd2);
    chk("t1_conflict", a_conflict, 4'd0);
    tick(4'b0000, 4'b0000);
    chk("t1_mem_en_off", a_mem_en, 1'b0);
    chk("t1_mem_we_off", a_mem_we, 1'b0);
    chk("t1_mem_addr_hold", a_mem_addr, 8'h10);
    chk("t1_no_wr_rsp_a", a_rsp_valid, 4'b0000);
    tick(4'b0000, 4'b0000);
    chk("t1_rsp_a", a_rsp_valid, 4'b0100);
    chk("t1_rdata_a", a_rsp_rdata, 32'hDEADBEEF);
    tick(4'b0000, 4'b0000);
    chk("t1_rsp_a_once", a_rsp_valid, 4'b0000);
    chk("t1_no_wr_rsp_b", b_rsp_valid, 4'b0000);
    tick(4'b0000, 4'b0000);
    chk("t1_rsp_b", b_rsp_valid, 4'b0100);
    chk("t1_rdata_b", b_rsp_rdata, 32'hDEADBEEF);
    tick(4'b0000, 4'b0000);
    chk("t1_rsp_b_once", b_rsp_valid, 4'b0000);

    // all four requesters contend for 8 cycles from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = 8'h20 + 8'(i);
      wdata_v[i] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'hF, 4'hF);
      exp_rdy = 4'b0001 << (k % 4);
      chk($sformatf("t2_ready_%0d", k), a_ready, exp_rdy);
      if (k > 0) chk($sformatf("t2_addr_%0d", k), a_mem_addr, 8'h20 + 8'((k - 1) % 4));
    end
    tick(4'h0, 4'h0);
    chk("t2_last_wdata", a_mem_wdata, 32'hA000_0003);
    chk("t2_grant_total_a", a_grant_total, 4'd8);
    chk("t2_conflict_a", a_conflict, 4'd8);
    chk("t2_grant_total_b", b_grant_total, 16'd8);
    chk("t2_conflict_b", b_conflict, 16'd8);

    // requesters 1 and 3 with the pointer parked at 2
    do_reset();
    tick(4'b0010, 4'hF);
    chk("t3_setup", a_ready, 4'b0010);
    tick(4'b1010, 4'hF);
    chk("t3_grant0", a_ready, 4'b1000);
    tick(4'b1010, 4'hF);
    chk("t3_grant1", a_ready, 4'b0010);
    tick(4'b1010, 4'hF);
    chk("t3_grant2", b_ready, 4'b1000);
    tick(4'h0, 4'h0);
    chk("t3_grant_total", b_grant_total, 16'd4);
    chk("t3_conflict", b_conflict, 16'd3);

    // interleaved reads: latency 3 on instance a, 5 on instance b
    do_reset();
    for (int off = 0; off < 11; off++) begin
      v = (off < 4) ? 4'hF : 4'h0;
      tick(v, 4'h0);
      exp_rdy = (off < 4) ? (4'b0001 << off) : 4'b0000;
      exp_a   = (off >= 3 && off <= 6) ? (4'b0001 << (off - 3)) : 4'b0000;
      exp_b   = (off >= 5 && off <= 8) ? (4'b0001 << (off - 5)) : 4'b0000;
      chk($sformatf("t4_ready_%0d", off), b_ready, exp_rdy);
      chk($sformatf("t4_rsp_a_%0d", off), a_rsp_valid, exp_a);
      chk($sformatf("t4_rsp_b_%0d", off), b_rsp_valid, exp_b);
      if (exp_a != 4'b0000)
        chk($sformatf("t4_rdata_a_%0d", off), a_rsp_rdata, 32'hA000_0000 + 32'(off - 3));
      if (exp_b != 4'b0000)
        chk($sformatf("t4_rdata_b_%0d", off), b_rsp_rdata, 32'hA000_0000 + 32'(off - 5));
    end

    // reset while two reads are in flight
    tick(4'b0011, 4'h0);
    chk("t5_rd0", a_ready, 4'b0001);
    tick(4'b0010, 4'h0);
    chk("t5_rd1", a_ready, 4'b0010);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("t5_mem_en", a_mem_en, 1'b0);
    chk("t5_mem_we", b_mem_we, 1'b0);
    chk("t5_mem_addr", a_mem_addr, 8'h00);
    chk("t5_mem_wdata", b_mem_wdata, 32'h0);
    chk("t5_grant_total", b_grant_total, 16'd0);
    chk("t5_conflict", b_conflict, 16'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b0101;
    req_we    = 4'hF;
    @(negedge clk);
    chk("t5_ptr_zero_a", a_ready, 4'b0001);
    chk("t5_ptr_zero_b", b_ready, 4'b0001);
    chk("t5_no_rsp_a_rel", a_rsp_valid, 4'b0000);
    for (int k = 0; k < 7; k++) begin
      tick(4'h0, 4'h0);
      chk($sformatf("t5_no_rsp_a_%0d", k), a_rsp_valid, 4'b0000);
      chk($sformatf("t5_no_rsp_b_%0d", k), b_rsp_valid, 4'b0000);
    end
    chk("t5_grant_after", b_grant_total, 16'd1);

    // counter saturation on the 4-bit instance
    do_reset();
    for (int k = 0; k < 20; k++) tick(4'hF, 4'hF);
    tick(4'h0, 4'h0);
    chk("t6_grant_sat_a", a_grant_total, 4'd15);
    chk("t6_conflict_sat_a", a_conflict, 4'd15);
    chk("t6_grant_b", b_grant_total, 16'd20);
    chk("t6_conflict_b", b_conflict, 16'd20);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
